fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage. Holds the program counter and issues word reads to instruction memory over a req/ready handshake. Registers each returned word with its PC into a one-entry IF/ID slot that drives the instruction splitter (`inst`) and the decode stage. Supports downstream stall and branch/jump redirect with squash of an in-flight fetch.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded at reset.
- `NOP_INST`, default 32'h0000_0000: value of `inst` when no valid instruction is held.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `stall` in 1: decode cannot accept; held instruction must not change.
- `redirect` in 1: single-cycle pulse; branch/jump taken.
- `redirect_pc` in 32: new fetch address; bits [1:0] ignored and forced to 0.
- `imem_req` out 1: read request.
- `imem_addr` out 32: word-aligned read address, stable while `imem_req` is high.
- `imem_ready` in 1: read completes this cycle; `imem_rdata` valid.
- `imem_rdata` in 32: instruction word.
- `inst` out 32: registered instruction to the splitter.
- `inst_pc` out 32: PC of `inst`.
- `inst_valid` out 1: `inst`/`inst_pc` hold a live instruction.

## Operation

- State machine: `IDLE` (no read outstanding), `WAIT` (read outstanding, keep result), `DROP` (read outstanding, discard result).
- Slot free this cycle = `!inst_valid || !stall`. The instruction is consumed on any cycle with `inst_valid && !stall`.
- `IDLE`: `imem_req = slot free && !redirect`, `imem_addr = pc`. If `imem_ready` is high in the same cycle: capture, and stay `IDLE`. Otherwise go to `WAIT`.
- `WAIT`: `imem_req` = 1 and `imem_addr` = pc, held until `imem_ready`. On ready: capture and return to `IDLE`.
- Capture: `inst <= imem_rdata`, `inst_pc <= pc`, `inst_valid <= 1`, `pc <= pc + 4` (wraps mod 2^32).
- Consume without capture: `inst_valid <= 0`, `inst <= NOP_INST`.
- `redirect` has priority over everything:
  - `pc <= {redirect_pc[31:2],2'b00}`; `inst_valid <= 0`; `inst <= NOP_INST`.
  - In `IDLE` with a request issuing, `imem_req` is suppressed (combinational gate). No read is started.
  - In `WAIT` or `DROP` without ready: go to `DROP`.
  - Ready in the same cycle as redirect: the response is discarded, and the next state is `IDLE`.
- `DROP`: `imem_req` stays 1 with the original address. The address is held in `req_addr`, not `pc`. On ready: discard data, go to `IDLE`. A further redirect in `DROP` only updates `pc`.
- `imem_addr` is driven from the `req_addr` register while in `WAIT`/`DROP`, and from `pc` in `IDLE`.
- At most one read is outstanding.
- `stall` never drops an outstanding read. Requests are only issued when the slot will be free at capture.

## Timing

- Reset values: `pc = RESET_PC`, state `IDLE`, `inst_valid = 0`, `inst = NOP_INST`, `inst_pc = RESET_PC`, `imem_req = 0` while `rst` is high.
- First cycle after reset deassert: `imem_req = 1`, `imem_addr = RESET_PC`.
- Zero-wait memory (ready same cycle as req): `inst_valid` is set on the next cycle, and throughput is 1 instruction per cycle while `stall` = 0.
- N-cycle memory: `inst` is valid 1 cycle after the ready cycle.
- Redirect-to-request: the cycle after `redirect` presents `redirect_pc` if not in `DROP`. In `DROP`, it comes the cycle after the discarded ready.
- `rst` mid-read: abandons the read immediately; memory must tolerate `imem_req` dropping.

## Structure

- Shared package `cpu_pkg`:
  - `RESET_PC` default.
  - `NOP_INST`.
  - `fetch_state_t` enum (`IDLE`, `WAIT`, `DROP`).
  - `INST_W` = 32.
- One natural sub-module: `fetch_pc`. It is the PC register with +4 increment, redirect load and alignment masking. The FSM and IF/ID slot stay in `fetch_unit`.

## Test plan

- Reset and stream:
  - Stimulus: reset, then zero-wait memory returning addr+0x1000.
  - Required: `imem_addr` 0,4,8…; `inst_valid` from cycle 2; `inst`=0x1000,0x1004,… with `inst_pc`=0,4,… one per cycle.
- Stall:
  - Stimulus: assert `stall` for 3 cycles while `inst`=0x1008 is valid.
  - Required: `inst`/`inst_pc` hold; `imem_req` = 0 after the pending read; resume at addr 0xC with no duplicate or lost word.
- Redirect, idle or same-cycle ready:
  - Stimulus: `redirect_pc`=0x203 at a cycle with ready.
  - Required: the returned word is dropped; `inst_valid`=0 next cycle; next `imem_addr`=0x200.
- Redirect during 3-cycle read:
  - Stimulus: redirect to 0x400 in cycle 1 of a read at 0x10.
  - Required: `imem_addr` stays 0x10 until ready; data discarded; next request 0x400; first valid `inst_pc`=0x400.
- Back-to-back redirects in `DROP`:
  - Stimulus: 0x400 then 0x800.
  - Required: next fetch is 0x800.
- Wrap and async reset:
  - Stimulus: `pc`=0xFFFF_FFFC, then fetch.
  - Required: next address 0x0.
  - Stimulus: `rst` mid-read.
  - Required: all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, reset defaults and fetch FSM encoding
package cpu_pkg;
    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [INST_W-1:0] DEFAULT_NOP_INST = 32'h0000_0000;
    typedef enum logic [1:0] {IDLE, WAIT, DROP} fetch_state_t;
endpackage

// File: rtl/fetch_pc.sv
// fetch_pc: program counter with +4 increment and word-aligned redirect load
module fetch_pc import cpu_pkg::*; #(
    parameter logic [INST_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              load,
    input  logic [INST_W-1:0] load_pc,
    output logic [INST_W-1:0] pc
);
    always_ff @(posedge clk or posedge rst)
        if (rst) pc <= RESET_PC;
        else if (load) pc <= load_pc & ~INST_W'(3);
        else if (inc) pc <= pc + INST_W'(4);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with req/ready memory handshake, one-entry IF/ID slot,
// stall hold and redirect that squashes any in-flight read
module fetch_unit import cpu_pkg::*; #(
    parameter logic [INST_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [INST_W-1:0] NOP_INST = DEFAULT_NOP_INST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [INST_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [INST_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] inst,
    output logic [INST_W-1:0] inst_pc,
    output logic              inst_valid
);
    fetch_state_t state, state_nx;
    logic [INST_W-1:0] pc, req_addr;
    logic slot_free, capture;

    assign slot_free = !inst_valid || !stall;
    assign capture = imem_req && imem_ready && state != DROP && !redirect;

    fetch_pc #(.RESET_PC(RESET_PC)) u_pc (
        .clk(clk),
        .rst(rst),
        .inc(capture),
        .load(redirect),
        .load_pc(redirect_pc),
        .pc(pc)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;

    // WAIT and DROP both leave on ready; a redirect only matters while not yet dropping
    always_comb
        state_nx = state == IDLE ? (imem_req && !imem_ready ? WAIT : IDLE)
                 : imem_ready ? IDLE : redirect ? DROP : state;

    always_comb begin
        imem_req = !rst && (state != IDLE || (slot_free && !redirect));
        imem_addr = state == IDLE ? pc : req_addr;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) req_addr <= RESET_PC;
        else if (state == IDLE) req_addr <= pc;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            inst_valid <= 1'b0;
            inst <= NOP_INST;
            inst_pc <= RESET_PC;
        end else if (redirect) begin
            inst_valid <= 1'b0;
            inst <= NOP_INST;
        end else if (capture) begin
            inst_valid <= 1'b1;
            inst <= imem_rdata;
            inst_pc <= pc;
        end else if (inst_valid && !stall) begin
            inst_valid <= 1'b0;
            inst <= NOP_INST;
        end
endmodule
